// File: rtl/wave_display_multi.sv
// wave_display_multi: overlays NUM_CH sample traces in one display window.
// Stage 0 forms the RAM address from the pixel column.
// Stage 1 compares each scaled sample against the row, using the RAM data.
// Stage 2 registers the window flag and the colour of the lowest-index hit.
module wave_display_multi #(
  parameter int                     NUM_CH      = 2,
  parameter int                     SAMPLE_W    = 8,
  parameter int                     ADDR_W      = 9,
  parameter int                     X_START     = 256,
  parameter int                     SCALE_SHIFT = 1,
  parameter int                     Y_OFFSET    = 32,
  parameter logic [NUM_CH*24-1:0]   CH_COLORS   = {24'hFFFFFF, 24'h00FF00},
  parameter logic [23:0]            BG_COLOR    = 24'h000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic                         freeze,
  input  logic [NUM_CH-1:0]            channel_enable,
  input  logic [NUM_CH*SAMPLE_W-1:0]   read_values,
  output logic [ADDR_W-1:0]            read_address,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  localparam int COL_W = ADDR_W - 1;
  localparam int WIN_W = 1 << ADDR_W;
  localparam int WIN_H = 1 << (SAMPLE_W + 1);

  // Stage 0 signals
  logic [31:0]          x_ext_s;
  logic [31:0]          y_ext_s;
  logic                 inwin_s;
  logic                 first_s;
  logic                 newcol_s;
  logic [COL_W-1:0]     col_s;
  logic                 bank_r;
  logic [ADDR_W-1:0]    last_addr_r;

  // Stage 1 registers and compute
  logic                 valid_s1_r;
  logic                 inwin_s1_r;
  logic                 newcol_s1_r;
  logic                 first_s1_r;
  logic [SAMPLE_W-1:0]  ycmp_s1_r;
  logic [SAMPLE_W-1:0]  prev_r    [NUM_CH];
  logic [SAMPLE_W-1:0]  cur_s     [NUM_CH];
  logic [SAMPLE_W-1:0]  ref_val_s [NUM_CH];
  logic [SAMPLE_W-1:0]  lo_s      [NUM_CH];
  logic [SAMPLE_W-1:0]  hi_s      [NUM_CH];
  logic [NUM_CH-1:0]    hit_s;
  logic [23:0]          color_s;
  logic                 pix_on_s;

  // Window test, column address and new-column detection for the incoming pixel
  always_comb begin
    x_ext_s  = {21'd0, x};
    y_ext_s  = {22'd0, y};
    inwin_s  = (x_ext_s >= 32'(X_START)) &&
               (x_ext_s < 32'(X_START + WIN_W)) &&
               (y_ext_s < 32'(WIN_H));
    col_s    = COL_W'((x_ext_s - 32'(X_START)) >> 1);
    first_s  = (x == 11'(X_START));
    if (inwin_s) begin
      read_address = {bank_r, col_s};
    end else begin
      read_address = {ADDR_W{1'b0}};
    end
    newcol_s = inwin_s && (first_s || (read_address != last_addr_r));
  end

  // Bank latch: sampled only at the first pixel of a frame, held while frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_r <= 1'b0;
    end else if (valid && (x == 11'd0) && (y == 10'd0) && !freeze) begin
      bank_r <= read_index;
    end
  end

  // Remember the last in-window address so a column change can be spotted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr_r <= {ADDR_W{1'b0}};
    end else if (valid && inwin_s) begin
      last_addr_r <= read_address;
    end
  end

  // Stage 1 pipeline registers, aligned with the RAM read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_s1_r  <= 1'b0;
      inwin_s1_r  <= 1'b0;
      newcol_s1_r <= 1'b0;
      first_s1_r  <= 1'b0;
      ycmp_s1_r   <= {SAMPLE_W{1'b0}};
    end else begin
      valid_s1_r  <= valid;
      inwin_s1_r  <= inwin_s;
      newcol_s1_r <= newcol_s;
      first_s1_r  <= first_s;
      ycmp_s1_r   <= SAMPLE_W'(y >> 1);
    end
  end

  // Per-channel trace test: row lies between the previous and current sample
  always_comb begin
    hit_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      cur_s[i]     = (read_values[i*SAMPLE_W +: SAMPLE_W] >> SCALE_SHIFT) + SAMPLE_W'(Y_OFFSET);
      ref_val_s[i] = first_s1_r ? cur_s[i] : prev_r[i];
      lo_s[i]      = (ref_val_s[i] < cur_s[i]) ? ref_val_s[i] : cur_s[i];
      hi_s[i]      = (ref_val_s[i] < cur_s[i]) ? cur_s[i] : ref_val_s[i];
      hit_s[i]     = channel_enable[i] & valid_s1_r & inwin_s1_r &
                     (lo_s[i] <= ycmp_s1_r) & (ycmp_s1_r <= hi_s[i]);
    end
  end

  // Previous-sample store, advanced only on the first pixel of each column
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_r[i] <= {SAMPLE_W{1'b0}};
      end
    end else if (valid_s1_r && newcol_s1_r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_r[i] <= cur_s[i];
      end
    end
  end

  // Colour pick: lowest-index hit wins, else background inside the window
  always_comb begin
    pix_on_s = valid_s1_r & inwin_s1_r;
    color_s  = pix_on_s ? BG_COLOR : 24'h000000;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      color_s = hit_s[i] ? CH_COLORS[i*24 +: 24] : color_s;
    end
  end

  // Stage 2 output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pixel <= 1'b0;
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
    end else begin
      valid_pixel <= pix_on_s;
      r           <= color_s[23:16];
      g           <= color_s[15:8];
      b           <= color_s[7:0];
    end
  end

endmodule

// File: tb/tb_wave_display_multi.sv
// Directed bench for wave_display_multi with default parameters and a
// behavioural 1-cycle synchronous sample RAM.
module tb_wave_display_multi;

  logic        clk;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic        freeze;
  logic [1:0]  channel_enable;
  logic [15:0] read_values;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  logic [7:0]  mem0 [512];
  logic [7:0]  mem1 [512];

  int checks;
  int errors;

  wave_display_multi dut (
    .clk            (clk),
    .reset          (reset),
    .x              (x),
    .y              (y),
    .valid          (valid),
    .read_index     (read_index),
    .freeze         (freeze),
    .channel_enable (channel_enable),
    .read_values    (read_values),
    .read_address   (read_address),
    .valid_pixel    (valid_pixel),
    .r              (r),
    .g              (g),
    .b              (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample RAM: data for the address of the previous cycle
  always @(posedge clk) begin
    read_values <= {mem1[read_address], mem0[read_address]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [10:0] xi, input logic [9:0] yi, input logic vi);
    x = xi;
    y = yi;
    valid = vi;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic [10:0] xi, input logic [9:0] yi, input logic vi);
    drive(xi, yi, vi);
    tick();
  endtask

  task automatic idle();
    step(11'd0, 10'd600, 1'b0);
  endtask

  function automatic logic [31:0] rgb();
    return {8'd0, r, g, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    x = 11'd0;
    y = 10'd0;
    valid = 1'b0;
    read_index = 1'b0;
    freeze = 1'b0;
    channel_enable = 2'b11;
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 8'd0;
      mem1[i] = 8'd254;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_vp", {31'd0, valid_pixel}, 32'd0);
    chk("reset_rgb", rgb(), 32'd0);
    chk("reset_addr", {23'd0, read_address}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single pixel: sample 0xC0 -> cur 128, drawn at ycmp 128 (y=256)
    mem0[0] = 8'hC0;
    step(11'd256, 10'd256, 1'b1);
    step(11'd256, 10'd258, 1'b1);
    chk("single_vp", {31'd0, valid_pixel}, 32'd1);
    chk("single_rgb", rgb(), 32'h00FF00);
    step(11'd256, 10'd160, 1'b1);
    chk("single_y258_vp", {31'd0, valid_pixel}, 32'd1);
    chk("single_y258_rgb", rgb(), 32'h000000);
    idle();
    chk("single_y160_rgb", rgb(), 32'h000000);
    idle();
    chk("idle_vp", {31'd0, valid_pixel}, 32'd0);
    chk("idle_rgb", rgb(), 32'h000000);

    // Vertical connector: column 0 cur=40, column 1 cur=60
    mem0[0] = 8'd16;
    mem0[1] = 8'd56;
    for (int yc = 39; yc <= 61; yc++) begin
      step(11'd256, 10'(2 * yc), 1'b1);
      step(11'd258, 10'(2 * yc), 1'b1);
      idle();
      chk("conn_vp", {31'd0, valid_pixel}, 32'd1);
      chk("conn_rgb", rgb(), (yc >= 40 && yc <= 60) ? 32'h00FF00 : 32'h000000);
    end

    // Overlap priority: both channels cur=82 at column 2
    mem0[2] = 8'd100;
    mem1[2] = 8'd100;
    step(11'd260, 10'd164, 1'b1);
    idle();
    chk("overlap_ch0", rgb(), 32'h00FF00);
    channel_enable = 2'b10;
    step(11'd260, 10'd164, 1'b1);
    idle();
    chk("overlap_ch1", rgb(), 32'hFFFFFF);
    channel_enable = 2'b00;
    step(11'd260, 10'd164, 1'b1);
    idle();
    chk("none_vp", {31'd0, valid_pixel}, 32'd1);
    chk("none_rgb", rgb(), 32'h000000);
    channel_enable = 2'b11;

    // Window edges
    drive(11'd255, 10'd100, 1'b1);
    chk("x255_addr", {23'd0, read_address}, 32'd0);
    tick();
    drive(11'd768, 10'd100, 1'b1);
    chk("x768_addr", {23'd0, read_address}, 32'd0);
    tick();
    chk("x255_vp", {31'd0, valid_pixel}, 32'd0);
    drive(11'd300, 10'd512, 1'b1);
    chk("y512_addr", {23'd0, read_address}, 32'd0);
    tick();
    chk("x768_vp", {31'd0, valid_pixel}, 32'd0);
    drive(11'd767, 10'd100, 1'b1);
    chk("x767_addr", {23'd0, read_address}, 32'h0FF);
    tick();
    chk("y512_vp", {31'd0, valid_pixel}, 32'd0);
    idle();
    chk("x767_vp", {31'd0, valid_pixel}, 32'd1);

    // Bank latch
    read_index = 1'b1;
    drive(11'd300, 10'd5, 1'b1);
    chk("bank_midframe", {23'd0, read_address}, 32'd22);
    tick();
    step(11'd0, 10'd0, 1'b1);
    drive(11'd300, 10'd5, 1'b1);
    chk("bank_latched", {23'd0, read_address}, 32'd278);
    read_index = 1'b0;
    tick();
    drive(11'd300, 10'd6, 1'b1);
    chk("bank_hold", {23'd0, read_address}, 32'd278);
    tick();
    freeze = 1'b1;
    step(11'd0, 10'd0, 1'b1);
    drive(11'd300, 10'd5, 1'b1);
    chk("bank_freeze", {23'd0, read_address}, 32'd278);
    tick();
    freeze = 1'b0;
    step(11'd0, 10'd0, 1'b1);
    drive(11'd300, 10'd5, 1'b1);
    chk("bank_relatch", {23'd0, read_address}, 32'd22);
    tick();
    idle();
    idle();

    // Asynchronous reset mid-line, then refill latency
    step(11'd256, 10'd80, 1'b1);
    idle();
    chk("prerst_rgb", rgb(), 32'h00FF00);
    #2;
    reset = 1'b1;
    #1;
    chk("async_vp", {31'd0, valid_pixel}, 32'd0);
    chk("async_rgb", rgb(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(11'd256, 10'd80, 1'b1);
    chk("refill1_vp", {31'd0, valid_pixel}, 32'd0);
    idle();
    chk("refill2_vp", {31'd0, valid_pixel}, 32'd1);
    chk("refill2_rgb", rgb(), 32'h00FF00);
    idle();
    chk("refill3_vp", {31'd0, valid_pixel}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
